// File: rtl/dmem_arbiter.sv
// dmem_arbiter: lets two requesters (load/store unit on port 0, debug/loader
// on port 1) share one single-port data memory. Only one transaction is in
// flight at a time. When both ports ask in the same IDLE cycle, the grant
// alternates between them. Reads come back after a fixed latency.
// Out-of-range addresses are reported on the port and never reach memory.
//
// Handshake: a requester raises mN_req with we/addr/wdata and holds them until
// it sees mN_gnt (a one-cycle pulse). A request is sampled only while the
// arbiter is IDLE, so req activity at any other time is ignored. A read
// finishes with a one-cycle mN_rvalid pulse. mN_rdata then holds its value
// until the next read on that same port completes.
module dmem_arbiter #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 9,
    parameter int DEPTH   = 300,
    parameter int MEM_LAT = 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_err,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_err,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // A zero-latency memory cannot be served by the WAIT state.
    if (MEM_LAT < 1) begin : g_bad_lat
        $error("dmem_arbiter: MEM_LAT must be at least 1");
    end

    localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // One extra bit so that DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t            state;
    logic              last_gnt;   // port granted by the last two-way arbitration
    logic              win;        // port that owns the current transaction
    logic              cap_we;     // captured direction of the current transaction
    logic              cap_oor;    // captured out-of-range flag
    logic [CNT_W-1:0]  cnt;        // read latency counter

    logic              both_req;
    logic              pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_oor;

    // Choose the winner of an IDLE arbitration and mux out its request fields.
    always_comb begin
        both_req  = m0_req & m1_req;
        pick      = 1'b0;
        if (both_req) begin
            pick = ~last_gnt;
        end else if (m1_req) begin
            pick = 1'b1;
        end
        sel_we    = pick ? m1_we    : m0_we;
        sel_addr  = pick ? m1_addr  : m0_addr;
        sel_wdata = pick ? m1_wdata : m0_wdata;
        sel_oor   = ({1'b0, sel_addr} >= DEPTH_X);
    end

    // Arbitration FSM; all port and memory outputs are registered here.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            win       <= 1'b0;
            cap_we    <= 1'b0;
            cap_oor   <= 1'b0;
            cnt       <= '0;
            m0_gnt    <= 1'b0;
            m0_err    <= 1'b0;
            m0_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_gnt    <= 1'b0;
            m1_err    <= 1'b0;
            m1_rvalid <= 1'b0;
            m1_rdata  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            // Pulses last one cycle unless a state below raises them again.
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_err    <= 1'b0;
            m1_err    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;

            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        // The rotation advances only when there was a real contest.
                        if (both_req) begin
                            last_gnt <= pick;
                        end
                        win     <= pick;
                        cap_we  <= sel_we;
                        cap_oor <= sel_oor;
                        m0_gnt  <= ~pick;
                        m1_gnt  <= pick;
                        if (sel_oor) begin
                            // Out-of-range accesses are flagged and never reach memory.
                            m0_err <= ~pick;
                            m1_err <= pick;
                        end else begin
                            mem_en    <= 1'b1;
                            mem_we    <= sel_we;
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
                        end
                        state <= ACCESS;
                        busy  <= 1'b1;
                    end
                end

                ACCESS: begin
                    if (cap_we) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt   <= CNT_ONE;
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (cnt == LAT_LAST) begin
                        // Only the owner's data register is updated. An
                        // out-of-range read returns zero.
                        if (win) begin
                            m1_rdata  <= cap_oor ? '0 : mem_rdata;
                            m1_rvalid <= 1'b1;
                        end else begin
                            m0_rdata  <= cap_oor ? '0 : mem_rdata;
                            m0_rvalid <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
